ball_motion_ctrl: RTL

//  Upstream steering stage for ballEngine: decides when the ball moves and in which

---
 rtl/ball_motion_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/ball_motion_ctrl.sv
// Ball steering stage ahead of ballEngine: paces moves from frame starts, bounces
// off walls/paddle/bricks, detects a lost ball and runs the serve/lost/game-over flow.
module ball_motion_ctrl #(
  parameter int UPDATE_DIV  = 2,
  parameter int STEP        = 3,
  parameter int BALL_SIZE   = 32,
  parameter int LEFT_WALL   = 0,
  parameter int RIGHT_WALL  = 640,
  parameter int TOP_WALL    = 0,
  parameter int PADDLE_Y    = 440,
  parameter int PADDLE_W    = 64,
  parameter int BOTTOM_LIM  = 480,
  parameter int LOST_FRAMES = 60,
  parameter int LIVES       = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frameStart,
  input  logic [9:0] xPos,
  input  logic [9:0] yPos,
  input  logic [9:0] paddleX,
  input  logic       launch,
  input  logic       brickHit,
  input  logic       brickHitVert,
  output logic       ballPosUpdate,
  output logic [1:0] direction,
  output logic       ballRespawn,
  output logic       ballLost,
  output logic [1:0] livesLeft,
  output logic       gameOver,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {IDLE, RUN, LOST, OVER} state_t;

  localparam int LW = $clog2(LOST_FRAMES + 1);
  localparam logic [3:0]    DIV_LAST   = 4'(UPDATE_DIV - 1);
  localparam logic [LW-1:0] LOST_LAST  = LW'(LOST_FRAMES - 1);
  localparam logic [10:0]   LEFT_LIM   = 11'(LEFT_WALL + STEP);
  localparam logic [10:0]   RIGHT_LIM  = 11'(RIGHT_WALL);
  localparam logic [10:0]   TOP_LIM    = 11'(TOP_WALL + STEP);
  localparam logic [10:0]   PADDLE_LIM = 11'(PADDLE_Y);
  localparam logic [10:0]   BOTTOM     = 11'(BOTTOM_LIM);
  localparam logic [10:0]   SZ         = 11'(BALL_SIZE);
  localparam logic [10:0]   SZ_STEP    = 11'(BALL_SIZE + STEP);
  localparam logic [10:0]   PW         = 11'(PADDLE_W);

  state_t        state, state_nx;
  logic [3:0]    frame_cnt, frame_cnt_nx;
  logic [LW-1:0] lost_cnt, lost_cnt_nx;
  logic [1:0]    dir_nx, lives_nx, eval_dir;
  logic          pend_v, pend_h, pend_v_nx, pend_h_nx;
  logic          upd_nx, resp_nx, lost_nx;
  logic          x_overlap, eval_lost;
  logic [10:0]   x_ext, y_ext, px_ext;

  // Zero-extended to 11 bits so a ball near x/y = 1023 cannot wrap past a wall.
  assign x_ext  = {1'b0, xPos};
  assign y_ext  = {1'b0, yPos};
  assign px_ext = {1'b0, paddleX};

  assign x_overlap = (x_ext + SZ > px_ext) && (x_ext < px_ext + PW);

  // Brick toggles first; walls and paddle then force absolute values over them.
  always_comb begin
    eval_dir = direction;
    if (pend_v || (brickHit && brickHitVert))  eval_dir[1] = ~eval_dir[1];
    if (pend_h || (brickHit && !brickHitVert)) eval_dir[0] = ~eval_dir[0];
    if (eval_dir[0] && (x_ext < LEFT_LIM))
      eval_dir[0] = 1'b0;
    else if (!eval_dir[0] && (x_ext + SZ_STEP > RIGHT_LIM))
      eval_dir[0] = 1'b1;
    if (eval_dir[1] && (y_ext < TOP_LIM))
      eval_dir[1] = 1'b0;
    if (!eval_dir[1] && (y_ext + SZ_STEP > PADDLE_LIM) && x_overlap)
      eval_dir[1] = 1'b1;
  end

  assign eval_lost = !eval_dir[1] && !x_overlap && (y_ext >= BOTTOM);

  always_comb begin
    state_nx     = state;
    frame_cnt_nx = frame_cnt;
    lost_cnt_nx  = lost_cnt;
    dir_nx       = direction;
    lives_nx     = livesLeft;
    pend_v_nx    = pend_v;
    pend_h_nx    = pend_h;
    upd_nx       = 1'b0;
    resp_nx      = 1'b0;
    lost_nx      = 1'b0;
    case (state)
      IDLE: begin
        if (launch) begin
          state_nx     = RUN;
          dir_nx       = 2'b10;
          frame_cnt_nx = '0;
        end
      end
      RUN: begin
        if (frameStart && (frame_cnt == DIV_LAST)) begin
          // EVAL: direction is registered here so it is stable under next cycle's strobe.
          frame_cnt_nx = '0;
          pend_v_nx    = 1'b0;
          pend_h_nx    = 1'b0;
          if (eval_lost) begin
            state_nx    = LOST;
            lost_nx     = 1'b1;
            lives_nx    = livesLeft - 2'd1;
            lost_cnt_nx = '0;
          end else begin
            dir_nx = eval_dir;
            upd_nx = 1'b1;
          end
        end else begin
          if (frameStart) frame_cnt_nx = frame_cnt + 4'd1;
          if (brickHit) begin
            if (brickHitVert) pend_v_nx = 1'b1;
            else              pend_h_nx = 1'b1;
          end
        end
      end
      LOST: begin
        if (frameStart) begin
          if (lost_cnt == LOST_LAST) begin
            lost_cnt_nx = '0;
            if (livesLeft != 2'd0) begin
              resp_nx  = 1'b1;
              state_nx = IDLE;
            end else begin
              state_nx = OVER;
            end
          end else begin
            lost_cnt_nx = lost_cnt + LW'(1);
          end
        end
      end
      OVER: begin
        if (launch) begin
          lives_nx = 2'(LIVES);
          resp_nx  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      frame_cnt     <= '0;
      lost_cnt      <= '0;
      direction     <= 2'b10;
      livesLeft     <= 2'(LIVES);
      pend_v        <= 1'b0;
      pend_h        <= 1'b0;
      ballPosUpdate <= 1'b0;
      ballRespawn   <= 1'b0;
      ballLost      <= 1'b0;
    end else begin
      state         <= state_nx;
      frame_cnt     <= frame_cnt_nx;
      lost_cnt      <= lost_cnt_nx;
      direction     <= dir_nx;
      livesLeft     <= lives_nx;
      pend_v        <= pend_v_nx;
      pend_h        <= pend_h_nx;
      ballPosUpdate <= upd_nx;
      ballRespawn   <= resp_nx;
      ballLost      <= lost_nx;
    end
  end

  assign gameOver  = (state == OVER);
  assign fsm_state = state;

endmodule
